// File: rtl/booth_pipe_pkg.sv
// booth_pipe_pkg
// Shared definitions for the Booth multiplier pipeline stages: default lane
// and accumulator widths, the stage-3 FSM state encoding, and a helper that
// sizes index ports so they stay at least one bit wide.
package booth_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 13;
  localparam int ACC_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // clog2 with a floor of 1 so a single-pair build still has a legal port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_pair_sum.sv
// booth_pair_sum
// Combinational datapath for one pair of stage-2 partial-product lanes:
// sign-extends both lanes to the accumulator width, weights lane 1 by
// 2^PAIR_SHIFT, then positions the pair by its index (k*2*PAIR_SHIFT).
// Ports:
//   in0, in1  : signed lanes of the pair
//   pair_idx  : position k of this pair within the product
//   term      : weighted pair value, modulo 2^ACC_WIDTH
module booth_pair_sum
  import booth_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int PAIR_SHIFT = 2,
  parameter int IDX_W      = 1
) (
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [IDX_W-1:0]      pair_idx,
  output logic [ACC_WIDTH-1:0]  term
);

  logic [ACC_WIDTH-1:0] ext0;
  logic [ACC_WIDTH-1:0] ext1;
  logic [ACC_WIDTH-1:0] pair_val;
  int                   pos_shift;

  // NOTE: every signal driven here is assigned on every path through the
  // block, so no latch is inferred.
  always_comb begin
    // Size cast of a signed operand replicates the sign bit.
    ext0      = ACC_WIDTH'($signed(in0));
    ext1      = ACC_WIDTH'($signed(in1));
    pair_val  = ext0 + (ext1 << PAIR_SHIFT);
    pos_shift = int'(pair_idx) * (2 * PAIR_SHIFT);
    // Bits shifted past the top are dropped: arithmetic wraps by design.
    term      = pair_val << pos_shift;
  end

endmodule

// File: rtl/stage3_accum.sv
// stage3_accum
// Third Booth pipeline stage: accepts NUM_PAIRS lane pairs from stage 2,
// accumulates their weighted sum and presents the finished product with a
// valid/ready handshake. Three-state FSM (IDLE -> ACC -> DONE).
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   clr                 : synchronous abort of the product in progress
//   in0, in1, in_valid  : incoming pair and its valid
//   in_ready            : pair accepted on this edge when in_valid is high
//   result, out_valid   : finished product and its valid
//   out_ready           : downstream consumes the result
//   pair_idx            : index of the next pair expected
module stage3_accum
  import booth_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PAIR_SHIFT = 2,
  parameter int NUM_PAIRS  = 2,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic [DATA_WIDTH-1:0]              in0,
  input  logic [DATA_WIDTH-1:0]              in1,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [ACC_WIDTH-1:0]               result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [idx_width(NUM_PAIRS)-1:0]    pair_idx
);

  localparam int                IDX_W    = idx_width(NUM_PAIRS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     pair_idx_q;
  logic [ACC_WIDTH-1:0] result_q;
  logic                 out_valid_q;
  logic                 in_ready_q;

  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 accept;

  booth_pair_sum #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .PAIR_SHIFT (PAIR_SHIFT),
    .IDX_W      (IDX_W)
  ) u_pair_sum (
    .in0      (in0),
    .in1      (in1),
    .pair_idx (pair_idx_q),
    .term     (term)
  );

  // Pair 0 starts a fresh product, so it overwrites instead of adding.
  always_comb begin
    acc_d  = (pair_idx_q == '0) ? term : (result_q + term);
    accept = in_valid && in_ready_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pair_idx_q  <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (clr) begin
      // Abort wins over acceptance and over the output handshake.
      state_q     <= IDLE;
      pair_idx_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            result_q <= acc_d;
            if (pair_idx_q == LAST_IDX) begin
              state_q     <= DONE;
              pair_idx_q  <= '0;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q    <= ACC;
              pair_idx_q <= pair_idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          // result_q is untouched here, so it holds under backpressure.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          pair_idx_q  <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign pair_idx  = pair_idx_q;

endmodule

// File: tb/tb_stage3_accum.sv
// tb_stage3_accum
// Scoreboard bench for stage3_accum: the driver feeds pairs and a reference
// model pushes the expected product when a product's last pair is accepted;
// a monitor drives out_ready and compares every consumed result.
module tb_stage3_accum;

  localparam int DW = 13;
  localparam int AW = 16;
  localparam int PS = 2;
  localparam int NP = 2;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] in0;
  logic [DW-1:0] in1;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] result;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] pair_idx;

  stage3_accum #(
    .DATA_WIDTH (DW),
    .PAIR_SHIFT (PS),
    .NUM_PAIRS  (NP),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in0       (in0),
    .in1       (in1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pair_idx  (pair_idx)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  logic [AW-1:0] exp_q[$];
  int            ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int            m_idx      = 0;
  longint        m_partial  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: product = sum_k (a_k + b_k * 2^PS) * 2^(k*2*PS) mod 2^AW
  task automatic model_accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa;
    longint sb;
    longint t;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = (sa + sb * (longint'(1) << PS)) * (longint'(1) << (m_idx * 2 * PS));
    if (m_idx == 0) m_partial = t;
    else            m_partial = m_partial + t;
    m_idx++;
    if (m_idx == NP) begin
      p = 64'(m_partial);
      exp_q.push_back(p[AW-1:0]);
      m_idx = 0;
    end
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      in0      = a;
      in1      = b;
      in_valid = 1'b1;
      if (in_ready) begin
        check("pair_idx_at_accept", 32'(pair_idx), 32'(m_idx));
        model_accept(a, b);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("in_ready_timeout", 32'(in_ready), 32'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Monitor: sets out_ready for the coming edge and scores the handshake.
  initial begin
    logic [AW-1:0] exp_v;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", 32'(result), 32'(exp_v));
        end
      end
    end
  end

  initial begin
    int cnt;
    int w;
    logic [AW-1:0] bp_exp;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pair_idx",  32'(pair_idx),  32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_accept", 32'(pair_idx), 32'd0);

    // Normal product: expect 16'h0027 with out_valid high one cycle.
    send_pair(13'd3, 13'd1);
    send_pair(13'd2, 13'd0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) cnt++;
    end
    check("out_valid_one_cycle", 32'(cnt), 32'd1);

    // Sign extension (16'hFFFF) and wrap (16'hFFC0).
    send_pair(13'h1FFF, 13'd0);
    send_pair(13'd0, 13'd0);
    idle(3);
    send_pair(13'd0, 13'd0);
    send_pair(13'd0, 13'h0FFF);
    idle(3);

    // Backpressure: stall downstream while in_valid stays high in DONE.
    ready_mode = 2;
    idle(1);
    send_pair(13'd5, 13'd1);
    send_pair(13'd7, 13'd3);
    bp_exp = 16'd313;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in0 = 13'($urandom);
      in1 = 13'($urandom);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_result",    32'(result),    32'(bp_exp));
    end
    @(negedge clk);
    in_valid   = 1'b0;
    ready_mode = 0;
    w = 0;
    while (out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("bp_release", 32'(out_valid), 32'd0);

    // clr in the cycle after pair 0, with in_valid high.
    send_pair(13'd3, 13'd1);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in0 = 13'd9; in1 = 13'd9;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    m_idx = 0;
    check("clr_pair_idx",  32'(pair_idx),  32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_in_ready",  32'(in_ready),  32'd1);
    send_pair(13'd3, 13'd1);
    send_pair(13'd2, 13'd0);
    idle(3);

    // Async reset between edges while in ACC.
    send_pair(13'd11, 13'd5);
    @(negedge clk);
    in_valid = 1'b0;
    check("acc_pair_idx", 32'(pair_idx), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_pair_idx",  32'(pair_idx),  32'd0);
    check("arst_result",    32'(result),    32'd0);
    m_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Randomized products under random backpressure.
    ready_mode = 1;
    repeat (40) begin
      for (int k = 0; k < NP; k++) begin
        send_pair(13'($urandom), 13'($urandom));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(1);
    ready_mode = 0;

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
